// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer states, opcode constants and PC helpers.
package cpu_pkg;

  localparam int unsigned INSTR_BYTES = 2;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  function automatic logic is_hlt(input logic [15:0] instr);
    return instr[15:12] == OP_HLT;
  endfunction

  // Sequential PC; wraps naturally at 16 bits.
  function automatic logic [15:0] pc_next(input logic [15:0] pc);
    return pc + 16'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry instruction/PC holding register used while ID is stalled.
module fetch_skid_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] d_instr,
  input  logic [15:0] d_pc,
  output logic        valid,
  output logic [15:0] instr,
  output logic [15:0] pc
);

  // Clear wins over load so a flush can never leave a stale word behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= 16'h0000;
      pc    <= 16'h0000;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc    <= d_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_seq.sv
// Fetch-stage PC sequencer: issues imem requests, feeds IF/ID, handles stall, redirect and HLT.
module pc_fetch_seq
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [15:0]  redirect_pc,
  output logic         imem_req,
  output logic [15:0]  imem_addr,
  input  logic         imem_ready,
  input  logic [15:0]  imem_data,
  output logic         if_valid,
  output logic [15:0]  if_instr,
  output logic [15:0]  if_pc,
  output logic [15:0]  if_pc_plus2,
  output logic         halted,
  output fetch_state_e dbg_state
);

  // Handshake: a request is outstanding whenever imem_req=1 and completes on
  // the cycle imem_ready=1; imem_addr holds until then. IF/ID words are taken
  // by ID on every edge where if_valid=1 and stall=0.

  fetch_state_e state;
  logic [15:0]  pc;
  logic [15:0]  target;

  logic         skid_load;
  logic         skid_clear;
  logic         skid_valid;
  logic [15:0]  skid_instr;
  logic [15:0]  skid_pc;

  assign skid_load  = (state == FETCH) && imem_ready && stall && !redirect_valid;
  assign skid_clear = (state == HELD) && (redirect_valid || !stall);

  fetch_skid_reg u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_instr (imem_data),
    .d_pc    (pc),
    .valid   (skid_valid),
    .instr   (skid_instr),
    .pc      (skid_pc)
  );

  // DRAIN keeps the old request up so the address stays stable until ready.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = pc;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      target      <= 16'h0000;
      if_valid    <= 1'b0;
      if_instr    <= 16'h0000;
      if_pc       <= 16'h0000;
      if_pc_plus2 <= 16'h0002;
      halted      <= 1'b0;
    end else begin
      if (!stall) if_valid <= 1'b0;

      if (redirect_valid) begin
        if_valid <= 1'b0;
        case (state)
          FETCH: begin
            if (imem_ready) begin
              pc <= redirect_pc;
            end else begin
              target <= redirect_pc;
              state  <= DRAIN;
            end
          end
          DRAIN: begin
            if (imem_ready) begin
              pc    <= redirect_pc;
              state <= FETCH;
            end else begin
              target <= redirect_pc;
            end
          end
          default: begin
            pc     <= redirect_pc;
            state  <= FETCH;
            halted <= 1'b0;
          end
        endcase
      end else begin
        case (state)
          FETCH: begin
            if (imem_ready) begin
              pc <= pc_next(pc);
              if (stall) begin
                state <= HELD;
              end else begin
                if_valid    <= 1'b1;
                if_instr    <= imem_data;
                if_pc       <= pc;
                if_pc_plus2 <= pc_next(pc);
                if (is_hlt(imem_data)) begin
                  state  <= HALT;
                  halted <= 1'b1;
                end
              end
            end
          end
          HELD: begin
            if (!stall && skid_valid) begin
              if_valid    <= 1'b1;
              if_instr    <= skid_instr;
              if_pc       <= skid_pc;
              if_pc_plus2 <= pc_next(skid_pc);
              if (is_hlt(skid_instr)) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                state <= FETCH;
              end
            end
          end
          DRAIN: begin
            if (imem_ready) begin
              pc    <= target;
              state <= FETCH;
            end
          end
          HALT: begin
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: directed scenarios plus randomized stall/latency traffic.
module tb_pc_fetch_seq;
  import cpu_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0100;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic         redirect_valid;
  logic [15:0]  redirect_pc;
  logic         imem_req;
  logic [15:0]  imem_addr;
  logic         imem_ready;
  logic [15:0]  imem_data;
  logic         if_valid;
  logic [15:0]  if_instr;
  logic [15:0]  if_pc;
  logic [15:0]  if_pc_plus2;
  logic         halted;
  fetch_state_e dbg_state;

  int checks   = 0;
  int failures = 0;
  int consumed = 0;

  logic        track_en = 1'b0;
  logic [15:0] exp_addr;
  logic [31:0] exp_q[$];
  logic [15:0] saved_addr;

  always #5 clk = ~clk;

  pc_fetch_seq #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2),
    .halted         (halted),
    .dbg_state      (dbg_state)
  );

  // Program image: HLT at 0x0010, elsewhere an address-derived non-HLT word.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    w = a ^ 16'h3C5A;
    if (w[15:12] == 4'hF) w[15:12] = 4'h7;
    if (a == 16'h0010) w = 16'hF000;
    return w;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, model/scoreboard at negedge, return at next posedge+1.
  task automatic cycle(input logic s, input logic r, input logic rv, input logic [15:0] rpc);
    logic [31:0] e;
    stall          = s;
    imem_ready     = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    if (track_en) begin
      if (imem_req) check("addr", 32'(imem_addr), 32'(exp_addr));
      if (imem_req && imem_ready) begin
        exp_q.push_back({exp_addr, mem_word(exp_addr)});
        exp_addr = exp_addr + 16'd2;
      end
      if (if_valid && !stall) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL sb_extra observed_pc=%h expected=none", if_pc);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          consumed++;
          check("sb_pc", 32'(if_pc), 32'(e[31:16]));
          check("sb_instr", 32'(if_instr), 32'(e[15:0]));
          check("sb_plus2", 32'(if_pc_plus2), 32'(16'(e[31:16] + 16'd2)));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; imem_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_addr", 32'(imem_addr), 32'(RST_PC));
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", 32'(if_instr), 32'h0);
    check("rst_if_pc", 32'(if_pc), 32'h0);
    check("rst_if_plus2", 32'(if_pc_plus2), 32'h2);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(FETCH));
    rst = 1'b0;
    exp_addr = RST_PC;
    track_en = 1'b1;

    // Always-ready streaming from RESET_PC.
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("first_pc", 32'(if_pc), 32'h0100);
    check("first_plus2", 32'(if_pc_plus2), 32'h0102);
    check("first_valid", 32'(if_valid), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("third_pc", 32'(if_pc), 32'h0104);

    // Three-cycle stall while memory is ready.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_hold_pc", 32'(if_pc), 32'h0104);
      check("stall_hold_valid", 32'(if_valid), 32'd1);
    end
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("release_pc", 32'(if_pc), 32'h0106);
    check("release_addr", 32'(imem_addr), 32'h0108);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check("stall_wait_addr", 32'(imem_addr), 32'h010A);

    // Randomized stall and memory latency.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("sb_activity", 32'(consumed > 100), 32'd1);
    track_en = 1'b0;

    // Redirect while a slow request is outstanding.
    saved_addr = exp_addr;
    cycle(1'b0, 1'b0, 1'b1, 16'h0400);
    check("drain_state", 32'(dbg_state), 32'(DRAIN));
    check("drain_req", 32'(imem_req), 32'd1);
    check("drain_addr", 32'(imem_addr), 32'(saved_addr));
    check("drain_flush", 32'(if_valid), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    check("drain_addr2", 32'(imem_addr), 32'(saved_addr));
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("drain_target", 32'(imem_addr), 32'h0400);
    check("drain_discard", 32'(if_valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("tgt_pc", 32'(if_pc), 32'h0400);
    check("tgt_instr", 32'(if_instr), 32'(mem_word(16'h0400)));
    check("tgt_valid", 32'(if_valid), 32'd1);

    // Newer redirect overwrites the saved target in DRAIN.
    cycle(1'b0, 1'b0, 1'b1, 16'h0500);
    cycle(1'b0, 1'b0, 1'b1, 16'h0600);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("drain_overwrite", 32'(imem_addr), 32'h0600);

    // HLT at 0x0010, then redirect out of HALT.
    cycle(1'b0, 1'b1, 1'b1, 16'h0010);
    check("redir_ready_addr", 32'(imem_addr), 32'h0010);
    check("redir_ready_flush", 32'(if_valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("hlt_valid", 32'(if_valid), 32'd1);
    check("hlt_instr", 32'(if_instr), 32'hF000);
    check("hlt_pc", 32'(if_pc), 32'h0010);
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_req", 32'(imem_req), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("halt_stays", 32'(halted), 32'd1);
    check("halt_no_req", 32'(imem_req), 32'd0);
    check("halt_no_valid", 32'(if_valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 16'h0020);
    check("unhalt", 32'(halted), 32'd0);
    check("unhalt_req", 32'(imem_req), 32'd1);
    check("unhalt_addr", 32'(imem_addr), 32'h0020);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("resume_pc", 32'(if_pc), 32'h0020);

    // Redirect together with stall.
    cycle(1'b1, 1'b1, 1'b1, 16'h0800);
    check("rs_flush", 32'(if_valid), 32'd0);
    check("rs_addr", 32'(imem_addr), 32'h0800);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    check("held_req", 32'(imem_req), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 16'h0900);
    check("held_redir_state", 32'(dbg_state), 32'(FETCH));
    check("held_redir_addr", 32'(imem_addr), 32'h0900);
    check("held_redir_flush", 32'(if_valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("held_redir_pc", 32'(if_pc), 32'h0900);

    // HLT captured under stall, then released.
    cycle(1'b0, 1'b1, 1'b1, 16'h0010);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    check("skid_hlt_not_yet", 32'(halted), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    check("skid_hlt_instr", 32'(if_instr), 32'hF000);
    check("skid_hlt_halted", 32'(halted), 32'd1);
    check("skid_hlt_req", 32'(imem_req), 32'd0);

    // Wrap from 0xFFFE.
    cycle(1'b0, 1'b0, 1'b1, 16'hFFFE);
    check("wrap_start", 32'(imem_addr), 32'hFFFE);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("wrap_pc", 32'(if_pc), 32'hFFFE);
    check("wrap_plus2", 32'(if_pc_plus2), 32'h0000);
    check("wrap_addr", 32'(imem_addr), 32'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    check("wrap_next_pc", 32'(if_pc), 32'h0000);
    check("wrap_next_plus2", 32'(if_pc_plus2), 32'h0002);

    // Reset mid-transaction.
    imem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_addr", 32'(imem_addr), 32'(RST_PC));
    check("rst2_valid", 32'(if_valid), 32'd0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
